// File: rtl/branch_resolve_unit.sv
// Branch resolution: evaluates the branch condition, computes the next PC,
// trains a table of 2-bit predictor counters and tracks mispredictions.
module branch_resolve_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic             out_valid,
    output logic             take_branch,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             illegal,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic [1:0]       bht [BHT_DEPTH];

    logic             accept_c;
    logic             legal_c;
    logic             cond_c;
    logic             take_c;
    logic             misp_c;
    logic [XLEN-1:0]  target_c;
    logic [IDX_W-1:0] upd_idx_c;
    logic [IDX_W-1:0] lk_idx_c;
    logic [1:0]       ctr_cur_c;
    logic [1:0]       ctr_next_c;
    logic [CNT_W-1:0] count_next_c;

    // Word-aligned PC bits select the counter; remaining bits only feed the adders.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

    assign lk_idx_c   = lookup_pc[IDX_W+1:2];
    assign pred_taken = bht[lk_idx_c][1];

    // Condition evaluation, next-PC, counter and mispredict-total next values.
    always_comb begin
        accept_c     = in_valid & ~flush;
        legal_c      = (funct3 != 3'b010) && (funct3 != 3'b011);
        cond_c       = 1'b0;
        case (funct3)
            F3_BEQ:  cond_c = (rs1_val == rs2_val);
            F3_BNE:  cond_c = (rs1_val != rs2_val);
            F3_BLT:  cond_c = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  cond_c = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: cond_c = (rs1_val <  rs2_val);
            F3_BGEU: cond_c = (rs1_val >= rs2_val);
            default: cond_c = 1'b0;
        endcase
        take_c       = legal_c & cond_c;
        misp_c       = legal_c & (take_c ^ in_pred_taken);
        target_c     = take_c ? (pc + imm) : (pc + XLEN'(4));

        upd_idx_c    = pc[IDX_W+1:2];
        ctr_cur_c    = bht[upd_idx_c];
        ctr_next_c   = ctr_cur_c;
        if (take_c) begin
            if (ctr_cur_c != 2'd3) ctr_next_c = ctr_cur_c + 2'd1;
        end else begin
            if (ctr_cur_c != 2'd0) ctr_next_c = ctr_cur_c - 2'd1;
        end

        count_next_c = mispredict_count;
        if (misp_c && (mispredict_count != {CNT_W{1'b1}}))
            count_next_c = mispredict_count + CNT_W'(1);
    end

    // Result registers, predictor table and mispredict total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid        <= 1'b0;
            take_branch      <= 1'b0;
            mispredict       <= 1'b0;
            illegal          <= 1'b0;
            redirect_pc      <= '0;
            mispredict_count <= '0;
            for (int i = 0; i < int'(BHT_DEPTH); i++) bht[i] <= 2'd1;
        end else begin
            out_valid <= accept_c;
            if (accept_c) begin
                take_branch      <= take_c;
                mispredict       <= misp_c;
                illegal          <= ~legal_c;
                redirect_pc      <= target_c;
                mispredict_count <= count_next_c;
                if (legal_c) bht[upd_idx_c] <= ctr_next_c;
            end else begin
                take_branch <= 1'b0;
                mispredict  <= 1'b0;
                illegal     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit against a table-based reference model.
module tb_branch_resolve_unit;

    localparam int BHT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1_val = '0, rs2_val = '0, pc = '0, imm = '0, lookup_pc = '0;
    logic        in_pred_taken = 1'b0;

    logic        pred_taken, out_valid, take_branch, mispredict, illegal;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_count;

    logic        pred_taken2, out_valid2, take_branch2, mispredict2, illegal2;
    logic [31:0] redirect_pc2;
    logic [1:0]  mispredict_count2;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .imm(imm),
        .in_pred_taken(in_pred_taken), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken), .out_valid(out_valid), .take_branch(take_branch),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .illegal(illegal),
        .mispredict_count(mispredict_count)
    );

    branch_resolve_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .imm(imm),
        .in_pred_taken(in_pred_taken), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken2), .out_valid(out_valid2), .take_branch(take_branch2),
        .mispredict(mispredict2), .redirect_pc(redirect_pc2), .illegal(illegal2),
        .mispredict_count(mispredict_count2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: counters as plain integers, totals as integers.
    int          m_bht [BHT];
    int          m_cnt, m_cnt2;
    logic        e_valid, e_take, e_misp, e_ill, e_pred, o_pred;
    logic [31:0] e_redir;

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    function automatic logic branch_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BHT; i++) m_bht[i] = 1;
        m_cnt = 0; m_cnt2 = 0;
        e_valid = 0; e_take = 0; e_misp = 0; e_ill = 0; e_redir = '0;
    endtask

    // Drive one cycle of inputs, predict the registered result, advance one edge.
    task automatic apply(input logic v, input logic fl, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im,
                         input logic pt, input logic [31:0] lk);
        logic acc, lgl, tk;
        in_valid = v; flush = fl; funct3 = f3; rs1_val = a; rs2_val = b;
        pc = p; imm = im; in_pred_taken = pt; lookup_pc = lk;
        #2;
        o_pred = pred_taken;
        e_pred = (m_bht[idx_of(lk)] >= 2);
        acc = v && !fl;
        lgl = (f3 != 3'd2) && (f3 != 3'd3);
        tk  = lgl && branch_cond(f3, a, b);
        if (acc) begin
            e_valid = 1; e_ill = !lgl; e_take = tk; e_misp = lgl && (tk != pt);
            e_redir = tk ? p + im : p + 32'd4;
            if (lgl) begin
                if (tk) m_bht[idx_of(p)] = (m_bht[idx_of(p)] == 3) ? 3 : m_bht[idx_of(p)] + 1;
                else    m_bht[idx_of(p)] = (m_bht[idx_of(p)] == 0) ? 0 : m_bht[idx_of(p)] - 1;
            end
            if (e_misp) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end else begin
            e_valid = 0; e_take = 0; e_misp = 0; e_ill = 0;
        end
        @(posedge clk);
        #1;
        in_valid = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 1; funct3 = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, take_branch, mispredict, illegal} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {out_valid, take_branch, mispredict, illegal});
        end
        checks++;
        if (redirect_pc !== 32'h0 || mispredict_count !== 16'h0) begin
            errors++; $display("FAIL reset_regs: redirect=%h count=%0d want 0/0", redirect_pc, mispredict_count);
        end
        for (int i = 0; i < 4; i++) begin
            lookup_pc = 32'(i * 52);
            #1;
            checks++;
            if (pred_taken !== 1'b0) begin
                errors++; $display("FAIL reset_pred: pc=%h got %b want 0", lookup_pc, pred_taken);
            end
        end
        in_valid = 0;
        rst = 0;
        model_reset();
    endtask

    task automatic test_beq_example();
        do_reset();
        apply(1, 0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 0, 32'h100);
        checks++;
        if ({out_valid, take_branch, mispredict, illegal} !== 4'b1110) begin
            errors++; $display("FAIL beq_flags: got %b want 1110", {out_valid, take_branch, mispredict, illegal});
        end
        checks++;
        if (redirect_pc !== 32'h120 || mispredict_count !== 16'd1) begin
            errors++; $display("FAIL beq_regs: redirect=%h count=%0d want 120/1", redirect_pc, mispredict_count);
        end
        checks++;
        if (o_pred !== 1'b0) begin
            errors++; $display("FAIL beq_pre_update_pred: got %b want 0", o_pred);
        end
        lookup_pc = 32'h100;
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL beq_pred_after: got %b want 1", pred_taken);
        end
        // Next cycle with no request must drop the flags but hold the redirect.
        apply(0, 0, 3'd0, 0, 0, 32'h500, 0, 0, 32'h100);
        checks++;
        if ({out_valid, take_branch, mispredict} !== 3'b000 || redirect_pc !== 32'h120) begin
            errors++; $display("FAIL idle_hold: flags=%b redirect=%h want 000/120", {out_valid, take_branch, mispredict}, redirect_pc);
        end
    endtask

    task automatic test_signed_unsigned();
        apply(1, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 32'h0);
        checks++;
        if (take_branch !== 1'b1 || redirect_pc !== 32'h210 || mispredict !== 1'b0) begin
            errors++; $display("FAIL blt_signed: take=%b redirect=%h misp=%b want 1/210/0", take_branch, redirect_pc, mispredict);
        end
        apply(1, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 32'h0);
        checks++;
        if (take_branch !== 1'b0 || redirect_pc !== 32'h204 || mispredict !== 1'b1) begin
            errors++; $display("FAIL bltu_unsigned: take=%b redirect=%h misp=%b want 0/204/1", take_branch, redirect_pc, mispredict);
        end
        apply(1, 0, 3'd5, 32'd1, 32'hFFFF_FFFF, 32'h300, 32'h8, 0, 32'h0);
        checks++;
        if (take_branch !== 1'b1) begin
            errors++; $display("FAIL bge_signed: got %b want 1", take_branch);
        end
        apply(1, 0, 3'd7, 32'd1, 32'hFFFF_FFFF, 32'h300, 32'h8, 0, 32'h0);
        checks++;
        if (take_branch !== 1'b0) begin
            errors++; $display("FAIL bgeu_unsigned: got %b want 0", take_branch);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] want_pred;
        want_pred = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 3'd0, 32'd7, 32'd7, 32'h40, 32'h4, 1, 32'h40);
        end
        checks++;
        if (m_bht[16] != 3) begin
            errors++; $display("FAIL sat_model: counter=%0d want 3", m_bht[16]);
        end
        apply(1, 0, 3'd1, 32'd7, 32'd7, 32'h40, 32'h4, 1, 32'h40);
        lookup_pc = 32'h40; #1;
        checks++;
        if (pred_taken !== want_pred[0]) begin
            errors++; $display("FAIL sat_first_nt: got %b want 1", pred_taken);
        end
        // Same-cycle lookup of the index being trained must see the old counter.
        apply(1, 0, 3'd1, 32'd7, 32'd7, 32'h40, 32'h4, 1, 32'h40);
        checks++;
        if (o_pred !== 1'b1) begin
            errors++; $display("FAIL sat_same_cycle: got %b want 1", o_pred);
        end
        lookup_pc = 32'h43; #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL sat_second_nt: got %b want 0", pred_taken);
        end
    endtask

    task automatic test_wrap();
        apply(1, 0, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1, 32'h0);
        checks++;
        if (redirect_pc !== 32'h4) begin
            errors++; $display("FAIL wrap_taken: got %h want 00000004", redirect_pc);
        end
        apply(1, 0, 3'd1, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 0, 32'h0);
        checks++;
        if (redirect_pc !== 32'h0 || take_branch !== 1'b0) begin
            errors++; $display("FAIL wrap_not_taken: redirect=%h take=%b want 0/0", redirect_pc, take_branch);
        end
    endtask

    task automatic test_illegal_flush();
        logic [15:0] cnt_before;
        logic [31:0] redir_before;
        cnt_before = mispredict_count;
        for (int f = 2; f <= 3; f++) begin
            apply(1, 0, 3'(f), 32'd9, 32'd9, 32'h80, 32'h40, 1, 32'h80);
            checks++;
            if ({out_valid, illegal, take_branch, mispredict} !== 4'b1100 || mispredict_count !== cnt_before) begin
                errors++; $display("FAIL illegal_%0d: flags=%b count=%0d want 1100/%0d", f,
                    {out_valid, illegal, take_branch, mispredict}, mispredict_count, cnt_before);
            end
        end
        lookup_pc = 32'h80; #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL illegal_bht: got %b want 0", pred_taken);
        end
        redir_before = redirect_pc;
        apply(1, 1, 3'd0, 32'd1, 32'd2, 32'h80, 32'h40, 1, 32'h80);
        checks++;
        if ({out_valid, illegal, take_branch, mispredict} !== 4'b0000 || mispredict_count !== cnt_before
            || redirect_pc !== redir_before) begin
            errors++; $display("FAIL flush: flags=%b count=%0d redirect=%h want 0000/%0d/%h",
                {out_valid, illegal, take_branch, mispredict}, mispredict_count, redirect_pc, cnt_before, redir_before);
        end
        lookup_pc = 32'h80; #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL flush_bht: got %b want 0", pred_taken);
        end
    endtask

    task automatic test_count_saturate();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 3'd0, 32'd3, 32'd3, 32'h600, 32'h8, 0, 32'h600);
            checks++;
            if (mispredict_count2 !== 2'(m_cnt2) || mispredict_count !== 16'(m_cnt)) begin
                errors++; $display("FAIL count_step%0d: narrow=%0d wide=%0d want %0d/%0d", i,
                    mispredict_count2, mispredict_count, m_cnt2, m_cnt);
            end
        end
        checks++;
        if (mispredict_count2 !== 2'd3 || mispredict_count !== 16'd5) begin
            errors++; $display("FAIL count_final: narrow=%0d wide=%0d want 3/5", mispredict_count2, mispredict_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, p, lk;
        logic [2:0]  f3;
        logic        v, fl;
        for (int i = 0; i < 300; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : a ^ 32'h8000_0000);
            p  = {$urandom_range(0, 3) == 0 ? 24'hFFFFFF : 24'(0), 8'($urandom_range(0, 15) << 2)};
            f3 = 3'($urandom_range(0, 7));
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 7) == 0);
            lk = ($urandom_range(0, 1) == 0) ? p : 32'($urandom_range(0, 255));
            apply(v, fl, f3, a, b, p, $urandom, 1'($urandom_range(0, 1)), lk);
            checks++;
            if ({out_valid, take_branch, mispredict, illegal} !== {e_valid, e_take, e_misp, e_ill}) begin
                errors++; $display("FAIL rand%0d_flags: got %b want %b", i,
                    {out_valid, take_branch, mispredict, illegal}, {e_valid, e_take, e_misp, e_ill});
            end
            checks++;
            if (redirect_pc !== e_redir || mispredict_count !== 16'(m_cnt) || mispredict_count2 !== 2'(m_cnt2)) begin
                errors++; $display("FAIL rand%0d_regs: redirect=%h count=%0d/%0d want %h %0d/%0d", i,
                    redirect_pc, mispredict_count, mispredict_count2, e_redir, m_cnt, m_cnt2);
            end
            checks++;
            if (o_pred !== e_pred) begin
                errors++; $display("FAIL rand%0d_pred: got %b want %b", i, o_pred, e_pred);
            end
        end
    endtask

    task automatic test_reset_midflight();
        apply(1, 0, 3'd0, 32'd1, 32'd1, 32'h700, 32'h8, 0, 32'h700);
        apply(1, 0, 3'd0, 32'd1, 32'd1, 32'h700, 32'h8, 0, 32'h700);
        in_valid = 1; funct3 = 3'd0; rs1_val = 1; rs2_val = 1; pc = 32'h700; in_pred_taken = 0;
        lookup_pc = 32'h700;
        #2;
        rst = 1;
        #1;
        checks++;
        if ({out_valid, take_branch, mispredict, illegal} !== 4'b0000 || redirect_pc !== 32'h0
            || mispredict_count !== 16'h0 || mispredict_count2 !== 2'h0) begin
            errors++; $display("FAIL async_reset: flags=%b redirect=%h count=%0d want all zero",
                {out_valid, take_branch, mispredict, illegal}, redirect_pc, mispredict_count);
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL async_reset_bht: got %b want 0", pred_taken);
        end
        @(posedge clk); #1;
        in_valid = 0;
        rst = 0;
        model_reset();
        apply(1, 0, 3'd1, 32'd1, 32'd2, 32'h700, 32'h8, 1, 32'h700);
        checks++;
        if ({out_valid, take_branch, mispredict} !== 3'b110 || mispredict_count !== 16'd0 || redirect_pc !== 32'h708) begin
            errors++; $display("FAIL post_reset: flags=%b count=%0d redirect=%h want 110/0/708",
                {out_valid, take_branch, mispredict}, mispredict_count, redirect_pc);
        end
        lookup_pc = 32'h700; #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL post_reset_bht: got %b want 1", pred_taken);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_beq_example();
        test_signed_unsigned();
        test_saturation();
        test_wrap();
        test_illegal_flush();
        test_count_saturate();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
